fu_issue_sched: RTL and testbench

Issue scheduler and result-bus arbiter for the execute stage. Decides each cycle whether the dispatched instruction may enter its functional unit: simple ALU, FP, complex ALU, predicate, or load/store queue. It reserves the single shared writeback slot at issue time, so fixed-latency units never collide. Variable-latency memory results fill the writeback cycles left unreserved.

---
 rtl/exec_pkg.sv | 29 ++
 rtl/wb_resv_table.sv | 50 +++++
 rtl/fu_issue_sched.sv | 151 +++++++++++++++
 tb/tb_fu_issue_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: functional-unit ids, default field widths
// and the writeback reservation entry.
package exec_pkg;

  localparam logic [2:0] FU_SIMPLE  = 3'd0;
  localparam logic [2:0] FU_FP      = 3'd1;
  localparam logic [2:0] FU_COMPLEX = 3'd2;
  localparam logic [2:0] FU_PRED    = 3'd3;
  localparam logic [2:0] FU_MEM     = 3'd4;
  localparam logic [2:0] FU_NOP     = 3'd5;

  localparam int EXEC_NUM_FU     = 5;
  localparam int EXEC_LAT_W      = 5;
  localparam int EXEC_MAX_LAT    = 16;
  localparam int EXEC_ROB_W      = 4;
  localparam int EXEC_STARVE_LIM = 8;

  typedef struct packed {
    logic                  valid;
    logic [2:0]            fu;
    logic [EXEC_ROB_W-1:0] rob;
  } wb_resv_t;

  // Units whose result cycle is known at issue and must hold a bus slot.
  function automatic logic is_fixed_fu(input logic [2:0] fu);
    return fu <= FU_PRED;
  endfunction

endpackage

// File: rtl/wb_resv_table.sv
// Writeback reservation shift register: shifts down one slot per cycle, slot 0 is the
// current bus owner; write lands at post-shift index L-1, free check looks at index L.
module wb_resv_table
  import exec_pkg::*;
#(
  parameter int MAX_LAT = EXEC_MAX_LAT,
  parameter int LAT_W   = EXEC_LAT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [LAT_W-1:0]      wr_lat,
  input  logic [2:0]            wr_fu,
  input  logic [EXEC_ROB_W-1:0] wr_rob,
  input  logic [LAT_W-1:0]      chk_lat,
  output logic                  chk_free,
  output logic                  head_vld,
  output logic [2:0]            head_fu,
  output logic [EXEC_ROB_W-1:0] head_rob
);

  localparam int IDX_W = $clog2(MAX_LAT);

  wb_resv_t         r_slot [MAX_LAT];
  wb_resv_t         w_wr_ent;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_chk_idx;

  assign w_wr_idx  = IDX_W'(wr_lat - 1'b1);
  assign w_chk_idx = IDX_W'(chk_lat);
  assign w_wr_ent  = '{valid: 1'b1, fu: wr_fu, rob: wr_rob};

  // Index MAX_LAT lies just past the table, so it is never occupied.
  assign chk_free = (32'(chk_lat) >= MAX_LAT) || !r_slot[w_chk_idx].valid;

  assign head_vld = r_slot[0].valid;
  assign head_fu  = r_slot[0].fu;
  assign head_rob = r_slot[0].rob;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LAT; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_LAT - 1; i++) r_slot[i] <= r_slot[i+1];
      r_slot[MAX_LAT-1] <= '0;
      if (wr_en) r_slot[w_wr_idx] <= w_wr_ent;
    end
  end

endmodule

// File: rtl/fu_issue_sched.sv
// Execute-stage issue scheduler and result-bus arbiter; ready/grant/wb outputs are combinational.
// Optional memory starvation guard: define FU_SCHED_STARVE_GUARD_EN.
module fu_issue_sched
  import exec_pkg::*;
#(
  parameter int NUM_FU  = EXEC_NUM_FU,
  parameter int LAT_W   = EXEC_LAT_W,
  parameter int MAX_LAT = EXEC_MAX_LAT,
  parameter int ROB_W   = EXEC_ROB_W
`ifdef FU_SCHED_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIM = EXEC_STARVE_LIM
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [2:0]        issue_fu,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic [ROB_W-1:0]  issue_rob,
  output logic              issue_ready,
  output logic [NUM_FU-1:0] issue_grant,
  input  logic              mem_full,
  input  logic              mem_done,
  input  logic [ROB_W-1:0]  mem_rob,
  output logic              mem_wb_grant,
  output logic              wb_valid,
  output logic [2:0]        wb_fu,
  output logic [ROB_W-1:0]  wb_rob,
  output logic [NUM_FU-1:0] fu_busy
);

  logic             w_fixed;
  logic             w_lat_ok;
  logic             w_slot_free;
  logic             w_unit_busy;
  logic             w_starve_block;
  logic             w_accept_fixed;
  logic             w_head_vld;
  logic [2:0]       w_head_fu;
  logic [ROB_W-1:0] w_head_rob;
  logic [LAT_W-1:0] r_cnt_fp;
  logic [LAT_W-1:0] r_cnt_cx;

  assign w_fixed  = is_fixed_fu(issue_fu);
  assign w_lat_ok = (issue_lat != '0) && (32'(issue_lat) <= MAX_LAT);

  always_comb begin
    w_unit_busy = 1'b0;
    case (issue_fu)
      FU_FP:      w_unit_busy = (r_cnt_fp != '0);
      FU_COMPLEX: w_unit_busy = (r_cnt_cx != '0);
      default:    w_unit_busy = 1'b0;
    endcase
  end

  always_comb begin
    issue_ready = 1'b0;
    if (reset) begin
      issue_ready = 1'b0;
    end else if (w_fixed) begin
      issue_ready = w_lat_ok && w_slot_free && !w_unit_busy && !w_starve_block;
    end else if (issue_fu == FU_MEM) begin
      issue_ready = !mem_full;
    end else begin
      issue_ready = 1'b1;
    end
  end

  always_comb begin
    issue_grant = '0;
    if (issue_valid && issue_ready && (issue_fu < 3'(NUM_FU))) issue_grant[issue_fu] = 1'b1;
  end

  assign w_accept_fixed = issue_valid && issue_ready && w_fixed;

  wb_resv_table #(
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (w_accept_fixed),
    .wr_lat   (issue_lat),
    .wr_fu    (issue_fu),
    .wr_rob   (issue_rob),
    .chk_lat  (issue_lat),
    .chk_free (w_slot_free),
    .head_vld (w_head_vld),
    .head_fu  (w_head_fu),
    .head_rob (w_head_rob)
  );

  // The accept cycle is the first busy cycle, so L-1 remain; re-issue lands at t+L.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_fp <= '0;
      r_cnt_cx <= '0;
    end else begin
      if (issue_grant[FU_FP])   r_cnt_fp <= issue_lat - 1'b1;
      else if (r_cnt_fp != '0)  r_cnt_fp <= r_cnt_fp - 1'b1;
      if (issue_grant[FU_COMPLEX]) r_cnt_cx <= issue_lat - 1'b1;
      else if (r_cnt_cx != '0)     r_cnt_cx <= r_cnt_cx - 1'b1;
    end
  end

  always_comb begin
    fu_busy             = '0;
    fu_busy[FU_FP]      = (r_cnt_fp != '0);
    fu_busy[FU_COMPLEX] = (r_cnt_cx != '0);
    fu_busy[FU_MEM]     = mem_full;
  end

  always_comb begin
    mem_wb_grant = 1'b0;
    wb_valid     = 1'b0;
    wb_fu        = '0;
    wb_rob       = '0;
    if (w_head_vld) begin
      wb_valid = 1'b1;
      wb_fu    = w_head_fu;
      wb_rob   = w_head_rob;
    end else if (mem_done) begin
      mem_wb_grant = 1'b1;
      wb_valid     = 1'b1;
      wb_fu        = FU_MEM;
      wb_rob       = mem_rob;
    end
  end

`ifdef FU_SCHED_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIM + 1);
  logic [SC_W-1:0] r_starve_cnt;

  // Saturates at the limit; fixed issue stays blocked until the bus frees up for memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (mem_done && !mem_wb_grant) begin
      if (r_starve_cnt != SC_W'(STARVE_LIM)) r_starve_cnt <= r_starve_cnt + 1'b1;
    end else begin
      r_starve_cnt <= '0;
    end
  end

  assign w_starve_block = (r_starve_cnt == SC_W'(STARVE_LIM));
`else
  assign w_starve_block = 1'b0;
`endif

endmodule

// File: tb/tb_fu_issue_sched.sv
// Self-checking bench for fu_issue_sched: directed scenarios plus randomized traffic
// against a cycle-booking reference model.
module tb_fu_issue_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [2:0] issue_fu;
  logic [4:0] issue_lat;
  logic [3:0] issue_rob;
  logic       issue_ready;
  logic [4:0] issue_grant;
  logic       mem_full;
  logic       mem_done;
  logic [3:0] mem_rob;
  logic       mem_wb_grant;
  logic       wb_valid;
  logic [2:0] wb_fu;
  logic [3:0] wb_rob;
  logic [4:0] fu_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fu_issue_sched dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_fu     (issue_fu),
    .issue_lat    (issue_lat),
    .issue_rob    (issue_rob),
    .issue_ready  (issue_ready),
    .issue_grant  (issue_grant),
    .mem_full     (mem_full),
    .mem_done     (mem_done),
    .mem_rob      (mem_rob),
    .mem_wb_grant (mem_wb_grant),
    .wb_valid     (wb_valid),
    .wb_fu        (wb_fu),
    .wb_rob       (wb_rob),
    .fu_busy      (fu_busy)
  );

`ifdef FU_SCHED_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // Reference model: the bus is booked by absolute cycle number; units 1/2 free again at a cycle.
  int cyc = 0;
  int bk_fu  [int];
  int bk_rob [int];
  int free_at [8];
  int starve_run = 0;

  function automatic bit m_ready();
    int L;
    int f;
    L = int'(issue_lat);
    f = int'(issue_fu);
    if (reset) return 1'b0;
    if (f <= 3)
      return (L >= 1) && (L <= 16) && !bk_fu.exists(cyc + L) && (cyc >= free_at[f]) &&
             !(GUARD && starve_run >= 8);
    if (f == 4) return !mem_full;
    return 1'b1;
  endfunction

  task automatic drive(input bit rst, input bit v, input int fu, input int lat, input int rob,
                       input bit mf, input bit md, input int mr);
    @(negedge clk);
    reset       = rst;
    issue_valid = v;
    issue_fu    = 3'(fu);
    issue_lat   = 5'(lat);
    issue_rob   = 4'(rob);
    mem_full    = mf;
    mem_done    = md;
    mem_rob     = 4'(mr);
    #1;
  endtask

  task automatic tick();
    bit rdy;
    bit mem_granted;
    int f;
    rdy         = m_ready();
    mem_granted = !bk_fu.exists(cyc) && mem_done;
    f           = int'(issue_fu);
    @(posedge clk);
    if (reset) begin
      bk_fu.delete();
      bk_rob.delete();
      for (int i = 0; i < 8; i++) free_at[i] = 0;
      starve_run = 0;
    end else begin
      if (issue_valid && rdy && f <= 3) begin
        bk_fu[cyc + int'(issue_lat)]  = f;
        bk_rob[cyc + int'(issue_lat)] = int'(issue_rob);
        if (f == 1 || f == 2) free_at[f] = cyc + int'(issue_lat);
      end
      if (mem_done && !mem_granted) starve_run++;
      else starve_run = 0;
    end
    if (bk_fu.exists(cyc)) begin
      bk_fu.delete(cyc);
      bk_rob.delete(cyc);
    end
    cyc++;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 1, 3, 0, 0, 0);
    n_tests++;
    if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", issue_ready); end
    n_tests++;
    if (issue_grant !== 5'b0) begin n_fail++; $display("FAIL rst_grant got=%b exp=00000", issue_grant); end
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    n_tests++;
    if ({wb_valid, wb_fu, mem_wb_grant, fu_busy} !== 10'b0) begin
      n_fail++; $display("FAIL rst_idle got v=%b fu=%0d mg=%b busy=%b exp all 0", wb_valid, wb_fu, mem_wb_grant, fu_busy);
    end
    tick();
    drive(0, 0, 0, 1, 0, 0, 1, 9);
    n_tests++;
    if ({wb_valid, wb_fu, wb_rob} !== {1'b1, 3'd4, 4'd9}) begin
      n_fail++; $display("FAIL rst_memwb got v=%b fu=%0d rob=%0d exp v=1 fu=4 rob=9", wb_valid, wb_fu, wb_rob);
    end
    tick();
  endtask

  task automatic test_lat1();
    do_reset();
    drive(0, 1, 0, 1, 3, 0, 0, 0);
    n_tests++;
    if (issue_grant !== 5'b00001) begin n_fail++; $display("FAIL l1_grant got=%b exp=00001", issue_grant); end
    tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    n_tests++;
    if ({wb_valid, wb_fu, wb_rob} !== {1'b1, 3'd0, 4'd3}) begin
      n_fail++; $display("FAIL l1_wb got v=%b fu=%0d rob=%0d exp v=1 fu=0 rob=3", wb_valid, wb_fu, wb_rob);
    end
    tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    n_tests++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL l1_after got=%b exp=0", wb_valid); end
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    drive(0, 1, 1, 4, 1, 0, 0, 0);
    n_tests++;
    if (issue_grant !== 5'b00010) begin n_fail++; $display("FAIL col_grant got=%b exp=00010", issue_grant); end
    tick();
    drive(0, 1, 0, 3, 2, 0, 0, 0);
    n_tests++;
    if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL col_refuse got=%b exp=0", issue_ready); end
    n_tests++;
    if (fu_busy[1] !== 1'b1) begin n_fail++; $display("FAIL col_busy1 got=%b exp=1", fu_busy[1]); end
    tick();
    for (int k = 2; k <= 3; k++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      n_tests++;
      if (fu_busy[1] !== 1'b1) begin n_fail++; $display("FAIL col_busy_t%0d got=%b exp=1", k, fu_busy[1]); end
      tick();
    end
    drive(0, 1, 1, 2, 4, 0, 0, 0);
    n_tests++;
    if ({issue_ready, fu_busy[1]} !== 2'b10) begin
      n_fail++; $display("FAIL col_reissue got rdy=%b busy=%b exp rdy=1 busy=0", issue_ready, fu_busy[1]);
    end
    n_tests++;
    if ({wb_valid, wb_fu, wb_rob} !== {1'b1, 3'd1, 4'd1}) begin
      n_fail++; $display("FAIL col_wb got v=%b fu=%0d rob=%0d exp v=1 fu=1 rob=1", wb_valid, wb_fu, wb_rob);
    end
    tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    n_tests++;
    if ({wb_valid, wb_fu, wb_rob} !== {1'b1, 3'd1, 4'd4}) begin
      n_fail++; $display("FAIL col_wb2 got v=%b fu=%0d rob=%0d exp v=1 fu=1 rob=4", wb_valid, wb_fu, wb_rob);
    end
    tick();
  endtask

  task automatic test_nonpipe();
    do_reset();
    drive(0, 1, 2, 5, 5, 0, 0, 0);
    n_tests++;
    if (issue_grant !== 5'b00100) begin n_fail++; $display("FAIL np_grant got=%b exp=00100", issue_grant); end
    tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    for (int k = 2; k <= 4; k++) begin
      drive(0, 1, 2, 5, 6, 0, 0, 0);
      n_tests++;
      if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL np_hold_t%0d got=%b exp=0", k, issue_ready); end
      tick();
    end
    drive(0, 1, 2, 5, 6, 0, 0, 0);
    n_tests++;
    if (issue_grant !== 5'b00100) begin n_fail++; $display("FAIL np_regrant got=%b exp=00100", issue_grant); end
    n_tests++;
    if ({wb_valid, wb_fu, wb_rob} !== {1'b1, 3'd2, 4'd5}) begin
      n_fail++; $display("FAIL np_wb1 got v=%b fu=%0d rob=%0d exp v=1 fu=2 rob=5", wb_valid, wb_fu, wb_rob);
    end
    tick();
    for (int k = 6; k <= 9; k++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    n_tests++;
    if ({wb_valid, wb_fu, wb_rob} !== {1'b1, 3'd2, 4'd6}) begin
      n_fail++; $display("FAIL np_wb2 got v=%b fu=%0d rob=%0d exp v=1 fu=2 rob=6", wb_valid, wb_fu, wb_rob);
    end
    tick();
  endtask

  task automatic test_mem();
    do_reset();
    drive(0, 1, 0, 1, 2, 0, 1, 7);
    n_tests++;
    if ({mem_wb_grant, wb_valid, wb_fu, wb_rob} !== {1'b1, 1'b1, 3'd4, 4'd7}) begin
      n_fail++; $display("FAIL mem_empty got mg=%b v=%b fu=%0d rob=%0d exp mg=1 v=1 fu=4 rob=7", mem_wb_grant, wb_valid, wb_fu, wb_rob);
    end
    tick();
    drive(0, 0, 0, 1, 0, 0, 1, 7);
    n_tests++;
    if ({mem_wb_grant, wb_fu, wb_rob} !== {1'b0, 3'd0, 4'd2}) begin
      n_fail++; $display("FAIL mem_lose got mg=%b fu=%0d rob=%0d exp mg=0 fu=0 rob=2", mem_wb_grant, wb_fu, wb_rob);
    end
    tick();
    drive(0, 1, 4, 0, 0, 1, 0, 0);
    n_tests++;
    if ({issue_ready, issue_grant, fu_busy} !== {1'b0, 5'b0, 5'b10000}) begin
      n_fail++; $display("FAIL mem_full got rdy=%b g=%b busy=%b exp rdy=0 g=00000 busy=10000", issue_ready, issue_grant, fu_busy);
    end
    tick();
    drive(0, 1, 4, 0, 0, 0, 0, 0);
    n_tests++;
    if (issue_grant !== 5'b10000) begin n_fail++; $display("FAIL mem_grant got=%b exp=10000", issue_grant); end
    tick();
    drive(0, 1, 6, 0, 0, 0, 0, 0);
    n_tests++;
    if ({issue_ready, issue_grant} !== {1'b1, 5'b0}) begin
      n_fail++; $display("FAIL nop got rdy=%b g=%b exp rdy=1 g=00000", issue_ready, issue_grant);
    end
    tick();
  endtask

  task automatic test_starve();
    int first_drop = -1;
    int first_mem  = -1;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(0, 1, 0, 1, c, 0, 1, 5);
      if (!issue_ready && first_drop < 0) first_drop = c;
      if (c > 0 && mem_wb_grant && first_mem < 0) first_mem = c;
      tick();
    end
    n_tests++;
    if (GUARD) begin
      if ({first_drop, first_mem} !== {32'sd9, 32'sd10}) begin
        n_fail++; $display("FAIL starve_guard got drop=%0d grant=%0d exp drop=9 grant=10", first_drop, first_mem);
      end
    end else begin
      if ({first_drop, first_mem} !== {-32'sd1, -32'sd1}) begin
        n_fail++; $display("FAIL starve_open got drop=%0d grant=%0d exp drop=-1 grant=-1", first_drop, first_mem);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_wb   = 0;
    int n_busy = 0;
    do_reset();
    drive(0, 1, 0, 5, 1, 0, 0, 0);
    tick();
    drive(0, 1, 3, 6, 2, 0, 0, 0);
    tick();
    drive(0, 1, 1, 8, 3, 0, 0, 0);
    n_tests++;
    if (issue_grant !== 5'b00010) begin n_fail++; $display("FAIL rmid_grant got=%b exp=00010", issue_grant); end
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      if (wb_valid) n_wb++;
      if (fu_busy != 5'b0) n_busy++;
      tick();
    end
    n_tests++;
    if ({n_wb, n_busy} !== 64'd0) begin
      n_fail++; $display("FAIL rmid_flush got wb=%0d busy=%0d exp wb=0 busy=0", n_wb, n_busy);
    end
  endtask

  task automatic test_random();
    bit         e_rdy;
    bit         e_hv;
    logic [4:0] e_grant;
    logic [4:0] e_busy;
    logic [8:0] e_wb;
    logic       e_mg;
    int         fu;
    int         lat;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      fu  = $urandom_range(0, 7);
      lat = ($urandom_range(0, 99) < 85) ? $urandom_range(1, 16) : $urandom_range(17, 31) % 32;
      if ($urandom_range(0, 9) == 0) lat = 0;
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7, fu, lat, $urandom_range(0, 15),
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
      e_rdy   = m_ready();
      e_grant = (issue_valid && e_rdy && fu <= 4) ? (5'b00001 << fu) : 5'b0;
      e_hv    = bk_fu.exists(cyc);
      e_mg    = !e_hv && mem_done;
      if (e_hv)          e_wb = {1'b1, 3'(bk_fu[cyc]), 4'(bk_rob[cyc])};
      else if (mem_done) e_wb = {1'b1, 3'd4, mem_rob};
      else               e_wb = 9'b0;
      e_busy = {mem_full, 1'b0, cyc < free_at[2], cyc < free_at[1], 1'b0};
      n_tests++;
      if (issue_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, issue_ready, e_rdy); end
      n_tests++;
      if (issue_grant !== e_grant) begin n_fail++; $display("FAIL rnd_grant n=%0d got=%b exp=%b", n, issue_grant, e_grant); end
      n_tests++;
      if ({wb_valid, wb_fu, wb_valid ? wb_rob : 4'd0} !== e_wb) begin
        n_fail++; $display("FAIL rnd_wb n=%0d got v=%b fu=%0d rob=%0d exp=%h", n, wb_valid, wb_fu, wb_rob, e_wb);
      end
      n_tests++;
      if (mem_wb_grant !== e_mg) begin n_fail++; $display("FAIL rnd_memgrant n=%0d got=%b exp=%b", n, mem_wb_grant, e_mg); end
      n_tests++;
      if (fu_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, fu_busy, e_busy); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_fu = '0; issue_lat = 5'd1; issue_rob = '0;
    mem_full = 1'b0; mem_done = 1'b0; mem_rob = '0;
    test_reset();
    test_lat1();
    test_collision();
    test_nonpipe();
    test_mem();
    test_starve();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
